adaptive_threshold_ctrl: RTL

- Per-frame controller for the 4-level binary pixel threshold stage.
- Each frame it counts, for every candidate level, how many valid pixels exceed that level.
- At frame end it selects the level whose "on" count is closest to a target fill count, and drives the 3-bit threshold select for the next frame.
- A manual mode lets a button step the level instead.

---
 rtl/threshold_pkg.sv | 19 +
 rtl/level_counter.sv | 44 ++++
 rtl/adaptive_threshold_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/threshold_pkg.sv
// Shared constants and types for the binary pixel threshold stage and its
// adaptive level controller.
package threshold_pkg;

    localparam int NUM_LEVELS = 4;
    localparam int LEVEL_W    = 7;
    localparam int IDX_W      = $clog2(NUM_LEVELS);

    // Candidate threshold levels, lowest first; a pixel is "on" when strictly above.
    localparam logic [LEVEL_W-1:0] THRESH_LEVELS [NUM_LEVELS] = '{7'd25, 7'd51, 7'd77, 7'd102};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        SELECT = 2'd2,
        UPDATE = 2'd3
    } state_t;

endpackage

// File: rtl/level_counter.sv
// Saturating count of valid pixels strictly above one threshold level.
module level_counter
    import threshold_pkg::*;
#(
    parameter int                 COUNT_WIDTH = 17,
    parameter logic [LEVEL_W-1:0] LEVEL       = 7'd0
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   clear,
    input  logic                   inc_en,
    input  logic [LEVEL_W-1:0]     pixel,
    output logic [COUNT_WIDTH-1:0] count
);

    logic [COUNT_WIDTH-1:0] count_reg;
    logic [COUNT_WIDTH-1:0] count_next;
    logic                   hit;
    logic                   saturated;

    assign hit       = inc_en && (pixel > LEVEL);
    assign saturated = &count_reg;

    // A clear in the same cycle as a hit starts the fresh frame at one.
    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = {{(COUNT_WIDTH-1){1'b0}}, hit};
        end else if (hit && !saturated) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/adaptive_threshold_ctrl.sv
// Per-frame threshold level controller: counts "on" pixels for each level,
// picks the level closest to the target fill, with a manual button override.
module adaptive_threshold_ctrl
    import threshold_pkg::*;
#(
    parameter int COUNT_WIDTH  = 17,
    parameter int TARGET_COUNT = 38400
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   pixel_valid_in,
    input  logic [LEVEL_W-1:0]     pixel_in,
    input  logic                   frame_start_in,
    input  logic                   frame_end_in,
    input  logic                   manual_mode_in,
    input  logic                   btn_step_in,
    output logic [2:0]             thresh_mux_out,
    output logic [COUNT_WIDTH-1:0] best_count_out,
    output logic                   select_done_out
);

    localparam logic [COUNT_WIDTH:0] TARGET_EXT = (COUNT_WIDTH+1)'(TARGET_COUNT);

    state_t                 state_reg;
    state_t                 state_next;
    logic                   cnt_clear;
    logic                   cnt_inc;
    logic [COUNT_WIDTH-1:0] count_arr [NUM_LEVELS];

    logic [IDX_W-1:0]       idx_reg;
    logic [IDX_W-1:0]       best_idx_reg;
    logic [COUNT_WIDTH:0]   best_dist_reg;
    logic [IDX_W-1:0]       level_reg;
    logic [COUNT_WIDTH-1:0] best_count_reg;
    logic                   select_done_reg;
    logic                   pending_reg;
    logic                   btn_prev_reg;
    logic                   btn_rise;

    logic [COUNT_WIDTH:0]   sel_ext;
    logic [COUNT_WIDTH:0]   sel_dist;

    generate
        for (genvar gi = 0; gi < NUM_LEVELS; gi++) begin : g_level
            level_counter #(
                .COUNT_WIDTH (COUNT_WIDTH),
                .LEVEL       (THRESH_LEVELS[gi])
            ) u_level_counter (
                .clk    (clk_in),
                .srst   (rst_in),
                .clear  (cnt_clear),
                .inc_en (cnt_inc),
                .pixel  (pixel_in),
                .count  (count_arr[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // frame_end wins over a coincident frame_start while accumulating.
    always_comb begin
        state_next = state_reg;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (frame_start_in) begin
                    cnt_clear  = 1'b1;
                    cnt_inc    = pixel_valid_in;
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                cnt_inc = pixel_valid_in;
                if (frame_end_in) begin
                    state_next = SELECT;
                end else if (frame_start_in) begin
                    cnt_clear = 1'b1;
                end
            end
            SELECT: begin
                if (idx_reg == IDX_W'(NUM_LEVELS - 1)) begin
                    state_next = UPDATE;
                end
            end
            UPDATE: begin
                if (pending_reg || frame_start_in) begin
                    cnt_clear  = 1'b1;
                    state_next = ACCUM;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign sel_ext  = {1'b0, count_arr[idx_reg]};
    assign sel_dist = (sel_ext >= TARGET_EXT) ? (sel_ext - TARGET_EXT) : (TARGET_EXT - sel_ext);
    assign btn_rise = btn_step_in && !btn_prev_reg;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            idx_reg         <= '0;
            best_idx_reg    <= '0;
            best_dist_reg   <= '0;
            level_reg       <= '0;
            best_count_reg  <= '0;
            select_done_reg <= 1'b0;
            pending_reg     <= 1'b0;
            btn_prev_reg    <= 1'b0;
        end else begin
            btn_prev_reg    <= btn_step_in;
            select_done_reg <= 1'b0;
            idx_reg         <= (state_reg == SELECT) ? idx_reg + 1'b1 : '0;

            // Strict less-than keeps the lower index on ties.
            if (state_reg == SELECT && (idx_reg == '0 || sel_dist < best_dist_reg)) begin
                best_dist_reg <= sel_dist;
                best_idx_reg  <= idx_reg;
            end

            if (state_reg == UPDATE) begin
                best_count_reg  <= count_arr[best_idx_reg];
                select_done_reg <= 1'b1;
                pending_reg     <= 1'b0;
                if (!manual_mode_in) begin
                    level_reg <= best_idx_reg;
                end
            end else if (state_reg == SELECT && frame_start_in) begin
                pending_reg <= 1'b1;
            end

            if (manual_mode_in && btn_rise) begin
                level_reg <= level_reg + 1'b1;
            end
        end
    end

    assign thresh_mux_out  = {1'b0, level_reg};
    assign best_count_out  = best_count_reg;
    assign select_done_out = select_done_reg;

endmodule
